// File: rtl/resp_demux_pkg.sv
// rtl/resp_demux_pkg.sv - shared constants for the 2:1 request mux and its response demux
// Purpose: select-bit encoding and default sizing shared by the request select
//          generation and resp_demux16b2.
// Contents: SEL_A / SEL_B select encodings, DEF_WIDTH / DEF_DEPTH defaults.
package resp_demux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/resp_demux16b2_sel_fifo.sv
// rtl/resp_demux16b2_sel_fifo.sv - 1-bit in-order tracker of issued request selects
// Purpose: remembers which requester issued each outstanding request, oldest first.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_bit (ignored while full)
//   push_bit    select bit of the issued request
//   pop         retire the head entry (ignored while empty)
//   head_bit    select bit of the oldest outstanding request
//   count       occupancy, 0..DEPTH
//   full        count == DEPTH
//   empty       count == 0
module sel_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       push_bit,
  input  logic                       pop,
  output logic                       head_bit,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en;
  logic             pop_en;

  // Full/empty come from the registered count, so a push while full is
  // dropped even when a pop happens in the same cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_bit;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_bit = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/resp_demux16b2.sv
// rtl/resp_demux16b2.sv - steers in-order memory responses back to requester A or B
// Purpose: records the select of every issued request and delivers each response
//          through a one-entry valid/ready register on the issuing requester's port.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_fire, req_sel           request issued this cycle and its requester (SEL_A/SEL_B)
//   tag_full, outstanding       tracker full flag and occupancy
//   rsp_valid, rsp_data         memory response
//   rsp_ready                   response accepted this cycle (combinational on a/b_ready)
//   a_valid, a_data, a_ready    requester A delivery
//   b_valid, b_data, b_ready    requester B delivery
//   err                         sticky overflow / unexpected-response flag
// Configuration: RESP_DEMUX16B2_ERR_EN compiles in error detection; otherwise err = 0.
module resp_demux16b2
  import resp_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_fire,
  input  logic                       req_sel,
  output logic                       tag_full,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  input  logic                       rsp_valid,
  input  logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_ready,
  output logic                       a_valid,
  output logic [WIDTH-1:0]           a_data,
  input  logic                       a_ready,
  output logic                       b_valid,
  output logic [WIDTH-1:0]           b_data,
  input  logic                       b_ready,
  output logic                       err
);

  logic             hd;
  logic             trk_empty;
  logic             accept;
  logic             a_valid_q, a_valid_d;
  logic             b_valid_q, b_valid_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;

  sel_fifo #(.DEPTH(DEPTH)) u_sel_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_fire),
    .push_bit (req_sel),
    .pop      (accept),
    .head_bit (hd),
    .count    (outstanding),
    .full     (tag_full),
    .empty    (trk_empty)
  );

  // The destination register may take a new response in the same cycle it
  // drains, which gives one response per cycle with ready held high.
  assign rsp_ready = !trk_empty &&
                     ((hd == SEL_B) ? (!b_valid_q || b_ready) : (!a_valid_q || a_ready));
  assign accept    = rsp_valid && rsp_ready;

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    if (a_valid_q && a_ready) a_valid_d = 1'b0;
    if (b_valid_q && b_ready) b_valid_d = 1'b0;
    // A reload overrides the drain above, so valid stays high.
    if (accept && (hd == SEL_A)) begin
      a_valid_d = 1'b1;
      a_data_d  = rsp_data;
    end
    if (accept && (hd == SEL_B)) begin
      b_valid_d = 1'b1;
      b_data_d  = rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
    end
  end

  assign a_valid = a_valid_q;
  assign a_data  = a_data_q;
  assign b_valid = b_valid_q;
  assign b_data  = b_data_q;

`ifdef RESP_DEMUX16B2_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (req_fire && tag_full) err_d = 1'b1;
    if (rsp_valid && trk_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/resp_demux16b2.md
# resp_demux16b2

Response-side companion to the 16-bit 2:1 request select mux in the memory-to-memory vector datapath. The mux merges two requesters (A, B) onto one memory port. This block steers each 16-bit memory response back to the requester that issued it. It records the select bit of every issued request in an in-order tracker and delivers each response through a one-entry output register per requester, using a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, data width of responses
- DEPTH, 4, maximum outstanding requests (power of two, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_fire  in  1  a request is issued to memory this cycle
- req_sel  in  1  issuing requester, same encoding as the request mux select (0 = A, 1 = B)
- tag_full  out  1  tracker holds DEPTH entries; the arbiter must not fire
- outstanding  out  $clog2(DEPTH+1)  current tracker occupancy
- rsp_valid  in  1  memory response valid
- rsp_data  in  WIDTH  memory response data
- rsp_ready  out  1  block accepts the response this cycle
- a_valid / a_data / a_ready  out / out / in  1 / WIDTH / 1  requester A delivery
- b_valid / b_data / b_ready  out / out / in  1 / WIDTH / 1  requester B delivery
- err  out  1  sticky protocol error

## Operation
- **Tracker push:** a 1-bit-wide FIFO of DEPTH entries. It pushes req_sel when req_fire && !tag_full.
- **Destination:** the FIFO head bit (hd) selects the target port.
- **rsp_ready:** (outstanding != 0) && (hd ? (!b_valid || b_ready) : (!a_valid || a_ready)).
- **Accept:** rsp_valid && rsp_ready. On accept:
  - pop the FIFO;
  - load rsp_data into the hd port's data register;
  - set that port's valid.
- **Port drain:** x_valid clears on x_valid && x_ready unless the port reloads in the same cycle; reload wins and valid stays 1.
- **Data hold:** x_data holds its value while x_valid=1 and !x_ready. While x_valid=0, x_data holds its last value.
- **Ordering:** responses are strictly in issue order. A stalled head blocks responses for the other port (no reordering).
- **Simultaneous push and pop:** legal whenever not full. Occupancy is unchanged.
- **Push while full:** the push is dropped even if a pop occurs in the same cycle, because tag_full is based on the registered occupancy.
- **Pointer wrap:** read and write pointers wrap modulo DEPTH.
- **Error conditions (sticky until reset):**
  - overflow: req_fire && tag_full;
  - unexpected response: rsp_valid while outstanding == 0.
  - A response arriving with an empty tracker is never accepted (rsp_ready = 0).

## Timing
- Reset values:
  - a_valid, b_valid, tag_full, err, rsp_ready = 0;
  - outstanding = 0;
  - a_data, b_data = 0;
  - FIFO pointers = 0.
- Reset asserted mid-operation clears all state asynchronously, including outstanding entries and pending port data. There is no recovery of in-flight responses.
- Latency:
  - accept → x_valid high on the next rising edge (1 cycle);
  - push → affects outstanding and tag_full next cycle.
- **Combinational paths:**
  - rsp_ready depends combinationally on a_ready/b_ready (same-cycle drain-and-reload, full throughput);
  - all other outputs are registered.
- Throughput: one response per cycle when the destination ready is held high.

## Configuration
- **Macro: RESP_DEMUX16B2_ERR_EN.**
- **Defined:** overflow and unexpected-response detection are compiled in, and err behaves as specified.
- **Undefined:** the detection logic is absent and err is tied to 0. All other behaviour is identical, including dropped pushes when full and rsp_ready = 0 when empty.

## Structure
- **Shared package (resp_demux_pkg):**
  - SEL_A = 1'b0, SEL_B = 1'b1;
  - default WIDTH = 16, DEPTH = 4.
  - The request mux select generation uses the same package constants.
- **Sub-module:** sel_fifo, a 1-bit synchronous FIFO.
  - Ports: push, push_bit, pop, head_bit, count, full, empty.
  - Same clk/rst_n.
- **Top level:** the port registers, the rsp_ready logic and the error flags stay in resp_demux16b2.

## Test plan
1. **Reset:** hold rst_n=0 with random inputs → all valids, tag_full, err, rsp_ready = 0 and outstanding = 0. Release rst_n → values hold until stimulus.
2. **Routing:** fire sel 0,1,0 on consecutive cycles; respond 0x1111, 0x2222, 0x3333 back-to-back with a_ready = b_ready = 1 → a_data 0x1111 then 0x3333, b_data 0x2222. Each delivery appears 1 cycle after its accept; outstanding ends at 0.
3. **Full:** issue 4 fires with no responses → tag_full = 1 and outstanding = 4. A 5th fire with sel=1 → occupancy stays 4 and err = 1 (macro defined). Undefine the macro and rerun → err stays 0. One response then frees a slot: tag_full = 0 next cycle.
4. **Backpressure:** issue sel 0,0,1 with a_ready = 0; respond 0xAAAA, 0xBBBB, 0xCCCC → a_data holds 0xAAAA and rsp_ready = 0 while 0xBBBB waits; 0xCCCC is not delivered. Raise a_ready → 0xBBBB loads the same cycle, then 0xCCCC reaches port B.
5. **Unexpected response:** assert rsp_valid with an empty tracker → rsp_ready = 0, no port valid, err = 1 and sticky.
6. **Mid-operation reset:** 2 entries outstanding, a_valid = 1 with a_ready = 0. Drop rst_n between clock edges → outputs clear immediately. After release, a new sel=1 fire with response 0x5A5A → b_data 0x5A5A.
